// File: rtl/cc_irq_watchdog_if.sv
`default_nettype none
// ============================================================================
//  Module   : cc_irq_watchdog_if
//  Purpose  : Bundles the decoder strobes, the video line counter and the
//             CPU-side IRQ / reset outputs of the IRQ-watchdog block.
//  Signals  : vcount     - current video line (VBITS wide)
//             WDOGn      - watchdog kick strobe, active low
//             INTACKn    - IRQ acknowledge strobe, active low
//             irq_n      - CPU IRQ line, active low
//             cpu_rst_wd - watchdog CPU reset request, active high
//             irq_missed - sticky flag, IRQ arrived while irq_n already low
//  Modports : master - decoder / video timing / CPU side
//             slave  - the IRQ-watchdog block
//  Revision : 1.0 - initial release
// ============================================================================
interface cc_irq_watchdog_if #(
    parameter int VBITS = 8
);
    logic [VBITS-1:0] vcount;
    logic             WDOGn;
    logic             INTACKn;
    logic             irq_n;
    logic             cpu_rst_wd;
    logic             irq_missed;

    modport master (
        output vcount,
        output WDOGn,
        output INTACKn,
        input  irq_n,
        input  cpu_rst_wd,
        input  irq_missed
    );

    modport slave (
        input  vcount,
        input  WDOGn,
        input  INTACKn,
        output irq_n,
        output cpu_rst_wd,
        output irq_missed
    );
endinterface
`default_nettype wire

// File: rtl/cc_irq_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : cc_irq_watchdog
//  Purpose  : Raises the CPU IRQ on selected video lines, clears it on the
//             INTACKn strobe, flags IRQs that arrive while one is pending,
//             and runs a frame-counting watchdog that pulses a CPU reset
//             when software stops writing WDOGn.
//  Ports    : clk    - system clock
//             reset  - synchronous, active-high reset
//             bus    - cc_irq_watchdog_if.slave (vcount, WDOGn, INTACKn in;
//                      irq_n, cpu_rst_wd, irq_missed out)
//  Config   : CC_WATCHDOG_EN - when defined, the frame counter and watchdog
//             FSM are built; when undefined, cpu_rst_wd is tied low and
//             WDOGn is ignored. IRQ logic is identical in both builds.
//  Revision : 1.0 - initial release
// ============================================================================
module cc_irq_watchdog #(
    parameter int VBITS       = 8,
    parameter int IRQ_DIV_BIT = 6,
    parameter int WDOG_FRAMES = 8,
    parameter int RST_CYCLES  = 16
) (
    input  wire               clk,
    input  wire               reset,
    cc_irq_watchdog_if.slave  bus
);

    // Elaboration-time sanity check of the configuration.
    if (WDOG_FRAMES < 1 || WDOG_FRAMES > 255 || RST_CYCLES < 1 || RST_CYCLES > 255 ||
        IRQ_DIV_BIT < 1 || IRQ_DIV_BIT > VBITS) begin : g_param_check
        $error("cc_irq_watchdog: parameter out of range");
    end

    logic [VBITS-1:0] r_vcount_q;
    logic             r_intack_q;
    logic             r_irq_n;
    logic             r_irq_missed;

    logic             w_line_evt;
    logic             w_irq_evt;
    logic             w_ack_evt;
    logic             w_firing;      // watchdog currently holding the CPU in reset
    logic             w_fire;        // watchdog enters FIRING on this edge
    logic             w_cpu_rst_wd;

    assign w_line_evt = (bus.vcount != r_vcount_q);
    assign w_irq_evt  = w_line_evt && (bus.vcount[IRQ_DIV_BIT-1:0] == '0);
    // Falling edge only: a strobe held low for several cycles is one event.
    assign w_ack_evt  = r_intack_q && !bus.INTACKn;

    // ------------------------------------------------------------------------
    // IRQ generation / acknowledge
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vcount_q   <= '0;
            r_intack_q   <= 1'b1;
            r_irq_n      <= 1'b1;
            r_irq_missed <= 1'b0;
        end else begin
            r_vcount_q <= bus.vcount;
            r_intack_q <= bus.INTACKn;
            if (w_firing || w_fire) begin
                // CPU is being reset: IRQ released and new IRQ events dropped,
                // including the one that coincides with the firing frame.
                r_irq_n <= 1'b1;
            end else if (w_irq_evt) begin
                // Set beats a simultaneous acknowledge; that ack consumes the
                // pending IRQ, so the new one is not counted as missed.
                r_irq_n <= 1'b0;
                if (!r_irq_n && !w_ack_evt) begin
                    r_irq_missed <= 1'b1;
                end
            end else if (w_ack_evt) begin
                r_irq_n <= 1'b1;
            end
        end
    end

`ifdef CC_WATCHDOG_EN
    // ------------------------------------------------------------------------
    // Frame watchdog
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_ARMED  = 1'b0;
    localparam logic [0:0] c_ST_FIRING = 1'b1;
    localparam logic [7:0] c_LAST_FRAME = 8'(WDOG_FRAMES - 1);
    localparam logic [7:0] c_RST_LOAD   = 8'(RST_CYCLES);

    logic [0:0] r_state;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_rst_cnt;
    logic       r_wdog_q;
    logic       r_cpu_rst_wd;
    logic       w_frame_evt;
    logic       w_kick_evt;

    assign w_frame_evt = w_line_evt && (bus.vcount == '0);
    assign w_kick_evt  = r_wdog_q && !bus.WDOGn;
    assign w_firing    = (r_state == c_ST_FIRING);
    // A kick in the same cycle as the last-allowed frame event prevents firing.
    assign w_fire      = !w_firing && w_frame_evt && !w_kick_evt &&
                         (r_frame_cnt == c_LAST_FRAME);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_ARMED;
            r_frame_cnt  <= 8'd0;
            r_rst_cnt    <= 8'd0;
            r_wdog_q     <= 1'b1;
            r_cpu_rst_wd <= 1'b0;
        end else begin
            r_wdog_q <= bus.WDOGn;
            if (r_state == c_ST_ARMED) begin
                if (w_kick_evt) begin
                    r_frame_cnt <= 8'd0;
                end else if (w_frame_evt) begin
                    if (r_frame_cnt == c_LAST_FRAME) begin
                        r_state      <= c_ST_FIRING;
                        r_rst_cnt    <= c_RST_LOAD;
                        r_frame_cnt  <= 8'd0;
                        r_cpu_rst_wd <= 1'b1;
                    end else if (r_frame_cnt != 8'hFF) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
            end else begin
                // Loaded with RST_CYCLES on entry; leaving at 1 gives exactly
                // RST_CYCLES cycles of cpu_rst_wd high.
                if (r_rst_cnt == 8'd1) begin
                    r_state      <= c_ST_ARMED;
                    r_cpu_rst_wd <= 1'b0;
                end else begin
                    r_rst_cnt <= r_rst_cnt - 8'd1;
                end
            end
        end
    end

    assign w_cpu_rst_wd = r_cpu_rst_wd;
`else
    assign w_firing     = 1'b0;
    assign w_fire       = 1'b0;
    assign w_cpu_rst_wd = 1'b0;
`endif

    assign bus.irq_n      = r_irq_n;
    assign bus.irq_missed = r_irq_missed;
    assign bus.cpu_rst_wd = w_cpu_rst_wd;

endmodule
`default_nettype wire
